grid_line_clear: RTL
====================

# grid_line_clear

Sequencer and arbiter for the Tetris grid memory (dual-port RAM, one row per word; port A read/write, port B read-only, registered outputs, write-through on address collision). On `start` it takes ownership of both ports, scans all rows bottom-up, drops every full row and compacts the rows above it downward, zero-fills the vacated top rows, and reports the number of lines cleared. While idle it passes the game-logic write/read port straight through to the memory.

## Interface
- `ROW_WIDTH`, 10: cells per row, equal to the memory data width.
- `ROWS`, 20: grid rows; row 0 is the top, row `ROWS-1` is the bottom.
- `ADDR_WIDTH`, 8: memory address width; `ROWS <= 2**ADDR_WIDTH`.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to run a clear pass; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the pass completes.
- `lines_cleared`  out  `$clog2(ROWS+1)`  number of full rows removed by the last pass.
- `ext_we`, `ext_addr_a[ADDR_WIDTH]`, `ext_data_a[ROW_WIDTH]`, `ext_addr_b[ADDR_WIDTH]`  in: game-logic port.
- `ext_stall`  out  1  equal to `busy`; ext requests issued while it is high are dropped, not queued.
- `mem_we_a`, `mem_addr_a`, `mem_data_a`, `mem_addr_b`  out: drive the grid memory.
- `mem_q_b`  in  `ROW_WIDTH`  memory port-B read data, valid 1 cycle after its address.

## Operation
- FSM states: IDLE, READ, EVAL, FILL, DONE.
- Pointers `rd` and `wr` are `ADDR_WIDTH+1` bits wide; they are signed so they can reach -1.
- IDLE:
  - Memory outputs mirror the ext inputs combinationally.
  - On `start`: `rd = wr = ROWS-1`, `lines_cleared = 0`, go to READ.
- READ:
  - `mem_addr_b = rd`, `mem_we_a = 0`; go to EVAL.
- EVAL (`mem_q_b` holds row `rd`):
  - If `&mem_q_b` (row full): `lines_cleared++`, no write.
  - Else: write `mem_q_b` to row `wr` only if `wr != rd`; then `wr--`.
  - Always `rd--`.
  - If `rd` was 0: go to FILL if `wr >= 0` after the update and `lines_cleared > 0`, otherwise go to DONE.
  - Else go to READ.
- FILL:
  - Write zeros to row `wr`, then `wr--`.
  - Leave for DONE when `wr` was 0. This costs exactly k cycles, k = `lines_cleared`.
- DONE:
  - `done = 1` for one cycle, then go to IDLE.
  - `lines_cleared` holds its value until the next accepted `start`.
- No RAW hazard: `wr >= rd` always, so every write targets a row that has already been read.
- `start` while busy: ignored.
- `start` in the DONE cycle: ignored; it is accepted only in IDLE.
- Reset (at any time, including mid-pass):
  - Outputs go immediately to `busy=0`, `done=0`, `lines_cleared=0`, `mem_we_a=0`, and the FSM returns to IDLE.
  - The grid is left partially compacted and is not restored.

## Timing
- Memory outputs in controller-owned states are registered-state-decoded, with no ext path.
- IDLE pass-through is combinational, zero added latency.
- Pass length: `done` is high in cycle `2*ROWS + k + 1`, counting the `start` sample cycle as cycle 0.
  - Example: ROWS=20, k=0 gives cycle 41.
- Rows are never rewritten in place. With no full rows the pass performs zero writes.
- `busy`/`ext_stall` rises in the cycle after `start` and falls in the cycle after `done`.

## Structure
- Shared package `tetris_pkg` holds `ROWS`, `ROW_WIDTH`, `ADDR_WIDTH`, and the state enum.
- One sub-module is natural: `grid_port_mux`. It selects between the ext port and the controller port on `busy`.
- The full-row detect is a single reduction AND inline, not a separate module.

## Test plan
- Grid preloaded with no full rows, `start` pulsed:
  - `done` in cycle 41, `lines_cleared=0`.
  - Zero `mem_we_a` cycles.
  - Grid unchanged.
- Row 19 = 0x3FF, row 18 = 0x155, row 17 = 0x0AA, others 0:
  - After the pass, row 19 = 0x155, row 18 = 0x0AA, row 0 = 0.
  - `lines_cleared=1`, `done` in cycle 42.
- Rows 19 and 17 full, row 18 = 0x001, row 16 = 0x200:
  - Row 19 = 0x001, row 18 = 0x200, rows 0–1 = 0.
  - `lines_cleared=2`.
- All 20 rows = 0x3FF:
  - `lines_cleared=20`, all rows 0.
  - FILL lasts 20 cycles, `done` in cycle 61.
- Mid-pass checks:
  - `start` re-pulsed mid-pass is ignored.
  - `ext_we=1` to row 5 mid-pass never reaches `mem_we_a` and `ext_stall=1`.
  - After `done`, an ext write to row 5 lands in the same cycle.
- `rst_n` asserted at cycle 15 of a pass:
  - `busy`, `done`, `mem_we_a` drop asynchronously.
  - A subsequent `start` runs a full, correct pass.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared grid geometry and the line-clear sequencer state encoding.
package tetris_pkg;
  localparam int ROWS       = 20;
  localparam int ROW_WIDTH  = 10;
  localparam int ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EVAL,
    ST_FILL,
    ST_DONE
  } state_e;
endpackage

// File: rtl/grid_port_mux.sv
// Hands the grid memory ports to the game logic when idle, to the line-clear
// controller while busy; ext requests made while busy are simply dropped.
module grid_port_mux #(
  parameter int ROW_WIDTH  = tetris_pkg::ROW_WIDTH,
  parameter int ADDR_WIDTH = tetris_pkg::ADDR_WIDTH
) (
  input  logic                  busy,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr_a,
  input  logic [ROW_WIDTH-1:0]  ext_data_a,
  input  logic [ADDR_WIDTH-1:0] ext_addr_b,
  input  logic                  ctl_we,
  input  logic [ADDR_WIDTH-1:0] ctl_addr_a,
  input  logic [ROW_WIDTH-1:0]  ctl_data_a,
  input  logic [ADDR_WIDTH-1:0] ctl_addr_b,
  output logic                  mem_we_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [ROW_WIDTH-1:0]  mem_data_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b
);
  always_comb begin
    if (busy) begin
      mem_we_a   = ctl_we;
      mem_addr_a = ctl_addr_a;
      mem_data_a = ctl_data_a;
      mem_addr_b = ctl_addr_b;
    end else begin
      mem_we_a   = ext_we;
      mem_addr_a = ext_addr_a;
      mem_data_a = ext_data_a;
      mem_addr_b = ext_addr_b;
    end
  end
endmodule

// File: rtl/grid_line_clear.sv
// Line-clear sequencer: scans the grid bottom-up, drops full rows, compacts
// the remaining rows downward and zero-fills the vacated top rows.
module grid_line_clear #(
  parameter int ROW_WIDTH  = tetris_pkg::ROW_WIDTH,
  parameter int ROWS       = tetris_pkg::ROWS,
  parameter int ADDR_WIDTH = tetris_pkg::ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(ROWS+1)-1:0]  lines_cleared,
  input  logic                       ext_we,
  input  logic [ADDR_WIDTH-1:0]      ext_addr_a,
  input  logic [ROW_WIDTH-1:0]       ext_data_a,
  input  logic [ADDR_WIDTH-1:0]      ext_addr_b,
  output logic                       ext_stall,
  output logic                       mem_we_a,
  output logic [ADDR_WIDTH-1:0]      mem_addr_a,
  output logic [ROW_WIDTH-1:0]       mem_data_a,
  output logic [ADDR_WIDTH-1:0]      mem_addr_b,
  input  logic [ROW_WIDTH-1:0]       mem_q_b
);
  import tetris_pkg::*;

  localparam int LC_W  = $clog2(ROWS+1);
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic signed [PTR_W-1:0] PTR_LAST = PTR_W'(ROWS-1);
  localparam logic signed [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic signed [PTR_W-1:0] PTR_ZERO = '0;

  state_e                   state_q, state_d;
  logic signed [PTR_W-1:0]  rd_q, rd_d;
  logic signed [PTR_W-1:0]  wr_q, wr_d;
  logic [LC_W-1:0]          lc_q, lc_d;

  logic                     ctl_we;
  logic [ADDR_WIDTH-1:0]    ctl_addr_a;
  logic [ROW_WIDTH-1:0]     ctl_data_a;
  logic [ADDR_WIDTH-1:0]    ctl_addr_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      lc_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      lc_q    <= lc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    lc_d       = lc_q;
    ctl_we     = 1'b0;
    ctl_addr_a = wr_q[ADDR_WIDTH-1:0];
    ctl_data_a = mem_q_b;
    ctl_addr_b = rd_q[ADDR_WIDTH-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_d    = PTR_LAST;
          wr_d    = PTR_LAST;
          lc_d    = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_EVAL;
      ST_EVAL: begin
        // A surviving row is copied only if it actually moves; wr never
        // drops below rd, so the target row has already been read.
        if (&mem_q_b) begin
          lc_d = lc_q + LC_W'(1);
        end else begin
          ctl_we = (wr_q != rd_q);
          wr_d   = wr_q - PTR_ONE;
        end
        rd_d = rd_q - PTR_ONE;
        if (rd_q == PTR_ZERO) begin
          if (!wr_d[PTR_W-1] && (lc_d != '0)) state_d = ST_FILL;
          else                                state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_FILL: begin
        ctl_we     = 1'b1;
        ctl_data_a = '0;
        wr_d       = wr_q - PTR_ONE;
        if (wr_q == PTR_ZERO) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign ext_stall     = busy;
  assign lines_cleared = lc_q;

  grid_port_mux #(
    .ROW_WIDTH (ROW_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_port_mux (
    .busy      (busy),
    .ext_we    (ext_we),
    .ext_addr_a(ext_addr_a),
    .ext_data_a(ext_data_a),
    .ext_addr_b(ext_addr_b),
    .ctl_we    (ctl_we),
    .ctl_addr_a(ctl_addr_a),
    .ctl_data_a(ctl_data_a),
    .ctl_addr_b(ctl_addr_b),
    .mem_we_a  (mem_we_a),
    .mem_addr_a(mem_addr_a),
    .mem_data_a(mem_data_a),
    .mem_addr_b(mem_addr_b)
  );
endmodule
